// File: rtl/x_post_crc_checker.sv
// ---------------------------------------------------------------------------
// x_post_crc_checker
//
// Post-configuration CRC checker. It scans a word-addressed readback source
// continuously, folds every word into a CRC register and compares the result
// of each full scan with a golden value.
//
// CRC: MSB-first, non-reflected, no final XOR. A whole readback word is
// folded in one cycle, RD_DATA[DATA_WIDTH-1] first.
//
// Build option:
//   POST_CRC_STICKY_EN  defined   : CRCERROR sets on a mismatch and holds
//                                   until RST.
//                       undefined : CRCERROR is rewritten at every CHECK
//                                   (1 = mismatch, 0 = match).
//
// Read handshake: RD_REQ is high for exactly one cycle (state REQ) with
// RD_ADDR valid in that cycle. The source answers with a single RD_VALID
// pulse carrying RD_DATA, at the earliest in the cycle after RD_REQ.
// RD_VALID is only accepted in WAIT; pulses in any other state are ignored,
// so at most one read is ever outstanding.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   EN         in   enable continuous scanning (sampled in IDLE and CHECK)
//   GOLDEN     in   expected CRC, sampled in CHECK
//   RD_REQ     out  one-cycle read request
//   RD_ADDR    out  word address, valid while RD_REQ=1
//   RD_VALID   in   read data valid
//   RD_DATA    in   read data, qualified by RD_VALID
//   BUSY       out  high in every state except IDLE
//   DONE       out  one-cycle pulse per completed scan
//   CRC_VALUE  out  running CRC register
//   CRCERROR   out  mismatch flag
//   dbg_state  out  current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 CHECK)
// ---------------------------------------------------------------------------
module x_post_crc_checker #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   CRC_WIDTH  = 32,
    parameter logic [31:0]          CRC_POLY   = 32'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT   = '1,
    parameter int                   NUM_WORDS  = 1024,
    parameter int                   ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [CRC_WIDTH-1:0]  GOLDEN,
    output logic                  RD_REQ,
    output logic [ADDR_WIDTH-1:0] RD_ADDR,
    input  logic                  RD_VALID,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [CRC_WIDTH-1:0]  CRC_VALUE,
    output logic                  CRCERROR,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    // Only the low CRC_WIDTH bits of the polynomial are meaningful.
    localparam logic [CRC_WIDTH-1:0]  POLY_W    = CRC_POLY[CRC_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

`ifdef POST_CRC_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [CRC_WIDTH-1:0]    crc_q,   crc_d;
    logic                    done_q,  done_d;
    logic                    err_q,   err_d;
    logic                    mismatch;

    // Fold one full word into the CRC, most significant data bit first.
    function automatic logic [CRC_WIDTH-1:0] crc_fold(
        input logic [CRC_WIDTH-1:0]  crc_in,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = crc_in;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ data[i];
            c  = {c[CRC_WIDTH-2:0], 1'b0};
            if (fb) begin
                c = c ^ POLY_W;
            end
        end
        return c;
    endfunction

    assign mismatch = (crc_q != GOLDEN);

    // Next-state and datapath decisions.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        crc_d   = crc_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    crc_d   = CRC_INIT;
                    addr_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (RD_VALID) begin
                    crc_d = crc_fold(crc_q, RD_DATA);
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_CHECK;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = S_REQ;
                    end
                end
            end
            S_CHECK: begin
                done_d = 1'b1;
                err_d  = STICKY ? (err_q | mismatch) : mismatch;
                // Back-to-back scans restart straight into REQ so the next
                // address-0 request coincides with the DONE pulse. When
                // stopping, the final CRC is left visible on CRC_VALUE.
                if (EN) begin
                    crc_d   = CRC_INIT;
                    addr_d  = '0;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            crc_q   <= CRC_INIT;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            crc_q   <= crc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign RD_REQ    = (state_q == S_REQ);
    assign RD_ADDR   = addr_q;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign CRC_VALUE = crc_q;
    assign CRCERROR  = err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/x_post_crc_checker.md
# x_post_crc_checker

Parametrised post-configuration CRC checker: continuously scans a word-addressed readback source, computes a configurable CRC over each full scan, and compares the result with a golden value. The next generation of the fixed CRCERROR-only post-CRC primitive, with configurable data width, polynomial, scan depth, a read handshake and scan status. Sits between the configuration readback memory and the device-level error reporting logic.

## Interface
- DATA_WIDTH, 32: bits per readback word; 1..64.
- CRC_WIDTH, 32: CRC register width; 8..32.
- CRC_POLY, 32'h04C11DB7: generator polynomial, implicit x^CRC_WIDTH term omitted.
- CRC_INIT, all ones: CRC register value at scan start.
- NUM_WORDS, 1024: words per scan; at least 2.
- ADDR_WIDTH, 10: address width; 2^ADDR_WIDTH >= NUM_WORDS.
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  enable continuous scanning.
- GOLDEN  in  CRC_WIDTH  expected CRC; sampled in CHECK.
- RD_REQ  out  1  one-cycle read request.
- RD_ADDR  out  ADDR_WIDTH  word address; valid while RD_REQ=1.
- RD_VALID  in  1  read data valid.
- RD_DATA  in  DATA_WIDTH  read data; qualified by RD_VALID.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse per completed scan.
- CRC_VALUE  out  CRC_WIDTH  running CRC register.
- CRCERROR  out  1  mismatch flag.

## Operation
- Reset: state IDLE; RD_REQ=0, RD_ADDR=0, BUSY=0, DONE=0, CRCERROR=0, CRC_VALUE=CRC_INIT.
- CRC: MSB-first, non-reflected, no final XOR. Each accepted word is shifted in DATA_WIDTH bits, RD_DATA[DATA_WIDTH-1] first, all bits in one cycle.
- IDLE: when EN=1, CRC_VALUE <= CRC_INIT, address <= 0, go to REQ.
- REQ: RD_REQ=1 with RD_ADDR = current address for exactly one cycle. Go to WAIT.
- WAIT: wait for RD_VALID=1 with no timeout. On RD_VALID, fold RD_DATA into CRC_VALUE. If address = NUM_WORDS-1, go to CHECK. Otherwise increment the address and go to REQ.
- CHECK: compare CRC_VALUE with GOLDEN. On the exiting edge, register DONE=1 and update CRCERROR (see Configuration).
  - If EN=1: reinit CRC_VALUE and the address, go to REQ.
  - If EN=0: go to IDLE; CRC_VALUE keeps the final value.
- EN is sampled only in IDLE and CHECK. Deasserting EN mid-scan lets the scan complete.
- RD_VALID is ignored outside WAIT. At most one outstanding read.
- RST during a scan aborts it immediately. No DONE; all outputs take their reset values next cycle.
- GOLDEN changes take effect at the next CHECK only.

## Timing
- RD_VALID may be asserted at the earliest in the WAIT cycle directly after REQ. Minimum 2 cycles per word.
- Minimum scan with zero-wait reads: 2*NUM_WORDS cycles in REQ/WAIT, plus 1 CHECK cycle. DONE and CRCERROR change in the cycle after CHECK.
- Back-to-back scans: the next RD_REQ for address 0 occurs in the same cycle DONE is high.
- From IDLE, EN high at edge N gives RD_REQ high in cycle N+1.
- CRC_VALUE updates on the edge that accepts RD_VALID.

## Configuration
- POST_CRC_STICKY_EN defined: CRCERROR is set on a mismatch and stays 1 until RST, whatever later scans return.
- Not defined: CRCERROR is rewritten at every CHECK: 1 on mismatch, 0 on match.

## Test plan
- Reset: hold RST with EN=1 for 3 cycles. RST=0 with EN=0: outputs stay at reset values, RD_REQ never asserts.
- Check value: DATA_WIDTH=8, CRC_WIDTH=32, NUM_WORDS=9.
  - Zero-wait source returns ASCII "123456789" and GOLDEN=32'h0376E6E7.
  - Required: CRC_VALUE=32'h0376E6E7 at CHECK, DONE pulse after cycle 19 from start, CRCERROR=0.
- Mismatch: same setup with GOLDEN=32'h0376E6E6 gives CRCERROR=1. Next scan with GOLDEN corrected:
  - POST_CRC_STICKY_EN defined: CRCERROR stays 1.
  - Not defined: CRCERROR returns to 0.
- Wait states: random 0–5 cycle RD_VALID delays and spurious RD_VALID pulses outside WAIT.
  - Required: identical CRC, exactly one RD_REQ per address 0..NUM_WORDS-1 in order, spurious pulses ignored.
- EN drop: deassert EN at word 4 of 9. Scan completes, one DONE pulse, FSM returns to IDLE, BUSY=0.
- Reset mid-scan: assert RST during WAIT of word 5. No DONE; CRC_VALUE=CRC_INIT, RD_ADDR=0 next cycle. Restart produces the correct CRC.
